// File: rtl/funct_gen_pipe_pkg.sv
// Shared decode constants for the ID-stage ALU function generator:
// opcode, SPECIAL funct and REGIMM rt codes plus field widths.
package funct_gen_pipe_pkg;

    // Instruction field widths
    localparam int OP_W    = 6;
    localparam int FUNCT_W = 6;
    localparam int RT_W    = 5;

    // Primary opcodes
    localparam logic [OP_W-1:0] OP_SPECIAL = 6'h00;
    localparam logic [OP_W-1:0] OP_REGIMM  = 6'h01;
    localparam logic [OP_W-1:0] OP_J       = 6'h02;
    localparam logic [OP_W-1:0] OP_JAL     = 6'h03;
    localparam logic [OP_W-1:0] OP_BEQ     = 6'h04;
    localparam logic [OP_W-1:0] OP_BNE     = 6'h05;
    localparam logic [OP_W-1:0] OP_BLEZ    = 6'h06;
    localparam logic [OP_W-1:0] OP_BGTZ    = 6'h07;
    localparam logic [OP_W-1:0] OP_ADDI    = 6'h08;
    localparam logic [OP_W-1:0] OP_ADDIU   = 6'h09;
    localparam logic [OP_W-1:0] OP_SLTI    = 6'h0a;
    localparam logic [OP_W-1:0] OP_SLTIU   = 6'h0b;
    localparam logic [OP_W-1:0] OP_ANDI    = 6'h0c;
    localparam logic [OP_W-1:0] OP_ORI     = 6'h0d;
    localparam logic [OP_W-1:0] OP_XORI    = 6'h0e;
    localparam logic [OP_W-1:0] OP_LUI     = 6'h0f;
    localparam logic [OP_W-1:0] OP_LB      = 6'h20;
    localparam logic [OP_W-1:0] OP_LH      = 6'h21;
    localparam logic [OP_W-1:0] OP_LW      = 6'h23;
    localparam logic [OP_W-1:0] OP_LBU     = 6'h24;
    localparam logic [OP_W-1:0] OP_LHU     = 6'h25;
    localparam logic [OP_W-1:0] OP_SB      = 6'h28;
    localparam logic [OP_W-1:0] OP_SH      = 6'h29;
    localparam logic [OP_W-1:0] OP_SW      = 6'h2b;

    // ALU function codes (SPECIAL funct encodings); NOP is sll $0,$0,0
    localparam logic [FUNCT_W-1:0] FUNCT_NOP  = 6'h00;
    localparam logic [FUNCT_W-1:0] FUNCT_ADD  = 6'h20;
    localparam logic [FUNCT_W-1:0] FUNCT_ADDU = 6'h21;
    localparam logic [FUNCT_W-1:0] FUNCT_SUB  = 6'h22;
    localparam logic [FUNCT_W-1:0] FUNCT_SUBU = 6'h23;
    localparam logic [FUNCT_W-1:0] FUNCT_AND  = 6'h24;
    localparam logic [FUNCT_W-1:0] FUNCT_OR   = 6'h25;
    localparam logic [FUNCT_W-1:0] FUNCT_XOR  = 6'h26;
    localparam logic [FUNCT_W-1:0] FUNCT_NOR  = 6'h27;
    localparam logic [FUNCT_W-1:0] FUNCT_SLT  = 6'h2a;
    localparam logic [FUNCT_W-1:0] FUNCT_SLTU = 6'h2b;

    // REGIMM rt codes
    localparam logic [RT_W-1:0] REGIMM_BLTZ   = 5'h00;
    localparam logic [RT_W-1:0] REGIMM_BGEZ   = 5'h01;
    localparam logic [RT_W-1:0] REGIMM_BLTZAL = 5'h10;
    localparam logic [RT_W-1:0] REGIMM_BGEZAL = 5'h11;

    // Loads and stores all use the adder for address generation
    function automatic logic is_mem_op(input logic [OP_W-1:0] op);
        case (op)
            OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_SB, OP_SH, OP_SW: is_mem_op = 1'b1;
            default:                                                  is_mem_op = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/funct_gen_pipe_lane_dec.sv
// Single-lane combinational decode of op/funct_in/rt into an ALU funct
// plus reserved-instruction and link-write flags. A disabled lane is a
// clean NOP with both flags low.
module funct_lane_dec
    import funct_gen_pipe_pkg::*;
(
    input  logic [OP_W-1:0]    op,
    input  logic [FUNCT_W-1:0] funct_in,
    input  logic [RT_W-1:0]    rt,
    input  logic               en,
    output logic [FUNCT_W-1:0] funct,
    output logic               illegal,
    output logic               link
);

    // Opcode decode; defaults describe a disabled lane
    always_comb begin
        funct   = FUNCT_NOP;
        illegal = 1'b0;
        link    = 1'b0;
        if (en) begin
            if (is_mem_op(op)) begin
                funct = FUNCT_ADD;
            end else begin
                case (op)
                    // SPECIAL funct legality is left to EX
                    OP_SPECIAL: funct = funct_in;
                    OP_ORI, OP_LUI: funct = FUNCT_OR;
                    OP_JAL: begin
                        funct = FUNCT_OR;
                        link  = 1'b1;
                    end
                    OP_ANDI:  funct = FUNCT_AND;
                    OP_XORI:  funct = FUNCT_XOR;
                    OP_ADDI:  funct = FUNCT_ADD;
                    OP_ADDIU: funct = FUNCT_ADDU;
                    OP_SLTI:  funct = FUNCT_SLT;
                    OP_SLTIU: funct = FUNCT_SLTU;
                    OP_J, OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: funct = FUNCT_NOP;
                    OP_REGIMM: begin
                        case (rt)
                            REGIMM_BLTZAL, REGIMM_BGEZAL: begin
                                funct = FUNCT_OR;
                                link  = 1'b1;
                            end
                            REGIMM_BLTZ, REGIMM_BGEZ: funct = FUNCT_NOP;
                            default: illegal = 1'b1;
                        endcase
                    end
                    default: illegal = 1'b1;
                endcase
            end
        end
    end

endmodule

// File: rtl/funct_gen_pipe.sv
// Multi-lane ALU function generator with a 2-entry skid buffer between
// ID and EX. in_ready depends only on occupancy and rst, so a stall from
// EX never forms a combinational path back into decode.
//
// Handshake: a bundle transfers on a rising edge where in_valid && in_ready
// (and no flush); the head entry transfers on out_valid && out_ready. The
// head is held stable while out_valid && !out_ready.
module funct_gen_pipe #(
    parameter int LANES   = 1,
    parameter int OP_W    = funct_gen_pipe_pkg::OP_W,
    parameter int FUNCT_W = funct_gen_pipe_pkg::FUNCT_W,
    parameter int RT_W    = funct_gen_pipe_pkg::RT_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [LANES-1:0]         lane_en,
    input  logic [LANES*OP_W-1:0]    op,
    input  logic [LANES*FUNCT_W-1:0] funct_in,
    input  logic [LANES*RT_W-1:0]    rt,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [LANES*FUNCT_W-1:0] funct_out,
    output logic [LANES-1:0]         illegal,
    output logic [LANES-1:0]         link
);
    import funct_gen_pipe_pkg::*;

    // Entry layout: {funct lanes, illegal lanes, link lanes}
    localparam int ENTRY_W = LANES * (FUNCT_W + 2);
    localparam logic [ENTRY_W-1:0] RESET_ENTRY = {{LANES{FUNCT_NOP}}, {(2*LANES){1'b0}}};

    logic [LANES*FUNCT_W-1:0] dec_funct;
    logic [LANES-1:0]         dec_illegal;
    logic [LANES-1:0]         dec_link;
    logic [ENTRY_W-1:0]       new_entry;
    logic [ENTRY_W-1:0]       head;
    logic [ENTRY_W-1:0]       tail;
    logic [1:0]               count;
    logic                     push;
    logic                     pop;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        funct_lane_dec u_dec (
            .op       (op[i*OP_W +: OP_W]),
            .funct_in (funct_in[i*FUNCT_W +: FUNCT_W]),
            .rt       (rt[i*RT_W +: RT_W]),
            .en       (lane_en[i]),
            .funct    (dec_funct[i*FUNCT_W +: FUNCT_W]),
            .illegal  (dec_illegal[i]),
            .link     (dec_link[i])
        );
    end

    assign new_entry = {dec_funct, dec_illegal, dec_link};

    assign in_ready  = (count != 2'd2) && !rst;
    assign out_valid = (count != 2'd0);
    // A flush-cycle bundle is dropped even when there is room for it
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready;

    // Buffer and occupancy update: rst beats flush, flush beats push/pop
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= 2'd0;
            head  <= RESET_ENTRY;
            tail  <= RESET_ENTRY;
        end else if (flush) begin
            count <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) head <= new_entry;
                    else               tail <= new_entry;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    head  <= tail;
                    count <= count - 2'd1;
                end
                // Only reachable at count 1: the new bundle replaces the head
                2'b11: head <= new_entry;
                default: ;
            endcase
        end
    end

    assign funct_out = head[ENTRY_W-1 -: LANES*FUNCT_W];
    assign illegal   = head[2*LANES-1 : LANES];
    assign link      = head[LANES-1 : 0];

endmodule

// File: tb/tb_funct_gen_pipe.sv
// Directed bench for funct_gen_pipe with two lanes: reset values, a
// decode vector table streamed at full rate, then hand-written
// backpressure, flush and reset-during-stall sequences.
module tb_funct_gen_pipe;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  lane_en;
    logic [11:0] op;
    logic [11:0] funct_in;
    logic [9:0]  rt;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] funct_out;
    logic [1:0]  illegal;
    logic [1:0]  link;

    int pass_cnt = 0;
    int total_cnt = 0;

    funct_gen_pipe #(.LANES(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .lane_en   (lane_en),
        .op        (op),
        .funct_in  (funct_in),
        .rt        (rt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .funct_out (funct_out),
        .illegal   (illegal),
        .link      (link)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [1:0] en;
        logic [5:0] op0;
        logic [5:0] fi0;
        logic [4:0] rt0;
        logic [5:0] op1;
        logic [5:0] fi1;
        logic [4:0] rt1;
        logic [5:0] ef0;
        logic [5:0] ef1;
        logic [1:0] eill;
        logic [1:0] elink;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic drive(input logic [1:0] en, input logic [5:0] op0, input logic [5:0] fi0,
                         input logic [4:0] rt0, input logic [5:0] op1, input logic [5:0] fi1,
                         input logic [4:0] rt1);
        lane_en  = en;
        op       = {op1, op0};
        funct_in = {fi1, fi0};
        rt       = {rt1, rt0};
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // name, en, op0, fi0, rt0, op1, fi1, rt1, exp funct0, exp funct1, exp illegal, exp link
        vecs[0]  = '{"ori_sw",        2'b11, 6'h0d, 6'h00, 5'h00, 6'h2b, 6'h00, 5'h00, 6'h25, 6'h20, 2'b00, 2'b00};
        vecs[1]  = '{"sltiu_special", 2'b11, 6'h0b, 6'h00, 5'h00, 6'h00, 6'h26, 5'h00, 6'h2b, 6'h26, 2'b00, 2'b00};
        vecs[2]  = '{"bgezal_rt5",    2'b11, 6'h01, 6'h00, 5'h11, 6'h01, 6'h00, 5'h05, 6'h25, 6'h00, 2'b10, 2'b01};
        vecs[3]  = '{"op3f_jal",      2'b11, 6'h3f, 6'h00, 5'h00, 6'h03, 6'h00, 5'h00, 6'h00, 6'h25, 2'b01, 2'b10};
        vecs[4]  = '{"andi_jal_off",  2'b01, 6'h0c, 6'h00, 5'h00, 6'h03, 6'h00, 5'h00, 6'h24, 6'h00, 2'b00, 2'b00};
        vecs[5]  = '{"lui_beq",       2'b11, 6'h0f, 6'h00, 5'h00, 6'h04, 6'h00, 5'h00, 6'h25, 6'h00, 2'b00, 2'b00};
        vecs[6]  = '{"addiu_slti",    2'b11, 6'h09, 6'h00, 5'h00, 6'h0a, 6'h00, 5'h00, 6'h21, 6'h2a, 2'b00, 2'b00};
        vecs[7]  = '{"bltz_xori",     2'b11, 6'h01, 6'h00, 5'h00, 6'h0e, 6'h00, 5'h00, 6'h00, 6'h26, 2'b00, 2'b00};
        vecs[8]  = '{"all_off",       2'b00, 6'h3f, 6'h00, 5'h00, 6'h01, 6'h00, 5'h05, 6'h00, 6'h00, 2'b00, 2'b00};
        vecs[9]  = '{"lw_addi",       2'b11, 6'h23, 6'h00, 5'h00, 6'h08, 6'h00, 5'h00, 6'h20, 6'h20, 2'b00, 2'b00};
        vecs[10] = '{"special3f_lbu", 2'b11, 6'h00, 6'h3f, 5'h00, 6'h24, 6'h00, 5'h00, 6'h3f, 6'h20, 2'b00, 2'b00};
        vecs[11] = '{"lb_j",          2'b11, 6'h20, 6'h00, 5'h00, 6'h02, 6'h00, 5'h00, 6'h20, 6'h00, 2'b00, 2'b00};
        vecs[12] = '{"bgez_sh",       2'b11, 6'h01, 6'h00, 5'h01, 6'h29, 6'h00, 5'h00, 6'h00, 6'h20, 2'b00, 2'b00};
        vecs[13] = '{"bltzal_bne",    2'b01, 6'h01, 6'h00, 5'h10, 6'h05, 6'h00, 5'h00, 6'h25, 6'h00, 2'b00, 2'b01};

        // Reset
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        drive(2'b00, 6'h0, 6'h0, 5'h0, 6'h0, 6'h0, 5'h0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_funct_out", funct_out, 0);
        check("rst_illegal", illegal, 0);
        check("rst_link", link, 0);
        check("rst_in_ready", in_ready, 0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", in_ready, 1);
        check("post_rst_out_valid", out_valid, 0);

        // Decode table streamed one bundle per cycle; each result one edge later
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].en, vecs[i].op0, vecs[i].fi0, vecs[i].rt0,
                  vecs[i].op1, vecs[i].fi1, vecs[i].rt1);
            tick();
            check($sformatf("%s.valid", vecs[i].name), out_valid, 1);
            check($sformatf("%s.funct", vecs[i].name), funct_out, {vecs[i].ef1, vecs[i].ef0});
            check($sformatf("%s.illegal", vecs[i].name), illegal, vecs[i].eill);
            check($sformatf("%s.link", vecs[i].name), link, vecs[i].elink);
        end
        in_valid = 1'b0;
        tick();
        check("drain_valid", out_valid, 0);

        // Backpressure: A=ORI/SW, B=ANDI/XORI, C=SLTIU/ADDIU
        out_ready = 1'b0;
        in_valid  = 1'b1;
        drive(2'b11, 6'h0d, 6'h0, 5'h0, 6'h2b, 6'h0, 5'h0);
        #1;
        check("bp_ready_a", in_ready, 1);
        tick();
        check("bp_valid_a", out_valid, 1);
        check("bp_head_a", funct_out, {6'h20, 6'h25});
        drive(2'b11, 6'h0c, 6'h0, 5'h0, 6'h0e, 6'h0, 5'h0);
        #1;
        check("bp_ready_b", in_ready, 1);
        tick();
        check("bp_hold_a1", funct_out, {6'h20, 6'h25});
        check("bp_full_ready", in_ready, 0);
        drive(2'b11, 6'h0b, 6'h0, 5'h0, 6'h09, 6'h0, 5'h0);
        tick();
        check("bp_hold_a2", funct_out, {6'h20, 6'h25});
        check("bp_full_ready2", in_ready, 0);
        check("bp_full_valid", out_valid, 1);
        out_ready = 1'b1;
        #1;
        check("bp_ready_indep", in_ready, 0);
        tick();
        check("bp_head_b", funct_out, {6'h26, 6'h24});
        check("bp_ready_after_pop", in_ready, 1);
        tick();
        check("bp_head_c", funct_out, {6'h21, 6'h2b});
        check("bp_valid_c", out_valid, 1);
        in_valid = 1'b0;
        tick();
        check("bp_empty", out_valid, 0);

        // Flush at count 2 with a bundle presented
        out_ready = 1'b0;
        in_valid  = 1'b1;
        drive(2'b01, 6'h03, 6'h0, 5'h0, 6'h00, 6'h0, 5'h0);
        tick();
        drive(2'b01, 6'h0e, 6'h0, 5'h0, 6'h00, 6'h0, 5'h0);
        tick();
        check("fl_full_ready", in_ready, 0);
        drive(2'b01, 6'h3f, 6'h0, 5'h0, 6'h00, 6'h0, 5'h0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        check("fl_valid", out_valid, 0);
        check("fl_ready", in_ready, 1);
        out_ready = 1'b1;
        tick();
        check("fl_no_ghost1", out_valid, 0);
        tick();
        check("fl_no_ghost2", out_valid, 0);

        // Flush at count 0 drops the bundle even though in_ready=1
        in_valid = 1'b1;
        flush    = 1'b1;
        drive(2'b01, 6'h0d, 6'h0, 5'h0, 6'h00, 6'h0, 5'h0);
        #1;
        check("fl0_ready", in_ready, 1);
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("fl0_dropped", out_valid, 0);
        tick();
        check("fl0_dropped2", out_valid, 0);

        // Reset during a stall
        out_ready = 1'b0;
        in_valid  = 1'b1;
        drive(2'b11, 6'h0d, 6'h0, 5'h0, 6'h03, 6'h0, 5'h0);
        tick();
        in_valid = 1'b0;
        check("rs_valid", out_valid, 1);
        check("rs_link", link, 2'b10);
        rst = 1'b1;
        tick();
        check("rs_out_valid", out_valid, 0);
        check("rs_funct", funct_out, 0);
        check("rs_link_clr", link, 0);
        check("rs_ready", in_ready, 0);
        rst = 1'b0;
        #1;
        check("rs_ready_after", in_ready, 1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
